// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
//
// Purpose:
//   WIDTH-bit register with a mode-selected next-state function (hold, load,
//   logical shift left/right, rotate left/right, arithmetic shift right) and
//   a self-timed serializer that loads a word and streams it out one bit per
//   clock with busy / sout_valid / done handshakes.
//
// Parameters:
//   WIDTH      register width, 2..64
//   RESET_VAL  value of q while reset is asserted
//   MSB_FIRST  1: serialize MSB first, 0: LSB first
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   en          clock enable for the mode operations (ignored while busy)
//   mode        operation select
//                 000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror,
//                 110 asr, 111 start serialize
//   pin         parallel load data
//   sin_l       bit shifted into the MSB on a logical right shift
//   sin_r       bit shifted into the LSB on a left shift
//   q           register contents
//   sout        serial data bit
//   sout_valid  high while sout carries a serialized bit
//   busy        high while a serialize sequence is in progress
//   done        one-cycle pulse after the last serialized bit
// ---------------------------------------------------------------------------
module universal_shift_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  // One extra bit so the counter can hold WIDTH itself without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             sout_reg, sout_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // Candidate next values for each mode, built bit by bit.
  logic [WIDTH-1:0] shl_vec;
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] rol_vec;
  logic [WIDTH-1:0] ror_vec;
  logic [WIDTH-1:0] asr_vec;
  logic [WIDTH-1:0] ser_vec;    // q after one serialize step
  logic [WIDTH-1:0] pin_step;   // pin after one serialize step (gapless restart)
  logic             ser_bit;    // bit leaving q on a serialize step
  logic             pin_bit;    // first bit of pin on a gapless restart

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bits
      // Left-moving operations: bit gi takes bit gi-1, bit 0 takes the fill.
      if (gi == 0) begin : g_lsb
        assign shl_vec[gi] = sin_r;
        assign rol_vec[gi] = q_reg[WIDTH-1];
      end else begin : g_lsb_n
        assign shl_vec[gi] = q_reg[gi-1];
        assign rol_vec[gi] = q_reg[gi-1];
      end

      // Right-moving operations: bit gi takes bit gi+1, the MSB takes the fill.
      if (gi == WIDTH-1) begin : g_msb
        assign shr_vec[gi] = sin_l;
        assign ror_vec[gi] = q_reg[0];
        assign asr_vec[gi] = q_reg[WIDTH-1];
      end else begin : g_msb_n
        assign shr_vec[gi] = q_reg[gi+1];
        assign ror_vec[gi] = q_reg[gi+1];
        assign asr_vec[gi] = q_reg[gi+1];
      end
    end

    // Serialize direction is fixed at elaboration; zero fill either way so
    // q is all zeros once every bit has left.
    if (MSB_FIRST) begin : g_ser_msb
      assign ser_vec  = {q_reg[WIDTH-2:0], 1'b0};
      assign ser_bit  = q_reg[WIDTH-1];
      assign pin_step = {pin[WIDTH-2:0], 1'b0};
      assign pin_bit  = pin[WIDTH-1];
    end else begin : g_ser_lsb
      assign ser_vec  = {1'b0, q_reg[WIDTH-1:1]};
      assign ser_bit  = q_reg[0];
      assign pin_step = {1'b0, pin[WIDTH-1:1]};
      assign pin_bit  = pin[0];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    sout_next  = 1'b0;
    valid_next = 1'b0;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (en) begin
          unique case (mode)
            3'b000: q_next = q_reg;
            3'b001: q_next = pin;
            3'b010: q_next = shl_vec;
            3'b011: q_next = shr_vec;
            3'b100: q_next = rol_vec;
            3'b101: q_next = ror_vec;
            3'b110: q_next = asr_vec;
            3'b111: begin
              state_next = S_SHIFT;
              busy_next  = 1'b1;
              if (done_reg) begin
                // Restart issued in the done cycle: the load cycle is folded
                // into this edge so the first bit goes out immediately and
                // sout_valid drops for the done cycle only.
                q_next     = pin_step;
                sout_next  = pin_bit;
                valid_next = 1'b1;
                cnt_next   = CW'(1);
              end else begin
                q_next   = pin;
                cnt_next = '0;
              end
            end
            default: q_next = q_reg;
          endcase
        end
      end

      S_SHIFT: begin
        // All inputs are ignored here, including a fresh mode=111.
        if (cnt_reg == LAST) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          q_next     = ser_vec;
          sout_next  = ser_bit;
          valid_next = 1'b1;
          cnt_next   = cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      q_reg     <= RESET_VAL;
      cnt_reg   <= '0;
      sout_reg  <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      sout_reg  <= sout_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign q          = q_reg;
  assign sout       = sout_reg;
  assign sout_valid = valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_universal_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Directed test of universal_shift_reg (WIDTH=4, RESET_VAL=1010, MSB first).
// A timeline model predicts the outputs after every clock edge; a compare
// process checks all outputs on every falling edge, and the stimulus adds
// literal expectations at the key points.
// ---------------------------------------------------------------------------
module tb_universal_shift_reg;

  localparam int         W    = 4;
  localparam logic [3:0] RV   = 4'b1010;
  localparam int         MOD  = 1 << W;
  localparam int         HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] pin;
  logic         sin_l;
  logic         sin_r;
  logic [W-1:0] q;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  universal_shift_reg #(
    .WIDTH     (W),
    .RESET_VAL (RV),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .pin        (pin),
    .sin_l      (sin_l),
    .sin_r      (sin_r),
    .q          (q),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  typedef struct {
    logic [W-1:0] q;
    logic         sout;
    logic         valid;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t m;
  exp_t e;
  exp_t sched[$];   // pre-computed outputs for the cycles of a serialize run
  logic gap;
  int   t;
  int   w;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m.q = RV; m.sout = 1'b0; m.valid = 1'b0; m.busy = 1'b0; m.done = 1'b0;
      sched.delete();
    end else if (sched.size() != 0) begin
      m = sched.pop_front();
    end else begin
      gap = m.done;
      m.sout = 1'b0; m.valid = 1'b0; m.busy = 1'b0; m.done = 1'b0;
      if (en && mode == 3'd7) begin
        w = int'(pin);
        for (int i = 0; i < W; i++) begin
          t       = (w << (i + 1)) % MOD;
          e.q     = t[W-1:0];
          e.sout  = ((w >> (W - 1 - i)) & 1) == 1;
          e.valid = 1'b1;
          e.busy  = 1'b1;
          e.done  = 1'b0;
          sched.push_back(e);
        end
        e.q = '0; e.sout = 1'b0; e.valid = 1'b0; e.busy = 1'b0; e.done = 1'b1;
        sched.push_back(e);
        if (gap) m = sched.pop_front();
        else begin
          m.q    = pin;
          m.busy = 1'b1;
        end
      end else begin
        t = int'(m.q);
        if (en) begin
          case (mode)
            3'd1: t = int'(pin);
            3'd2: t = (t * 2 + int'(sin_r)) % MOD;
            3'd3: t = t / 2 + int'(sin_l) * HALF;
            3'd4: t = (t * 2) % MOD + t / HALF;
            3'd5: t = t / 2 + (t % 2) * HALF;
            3'd6: t = t / 2 + (t / HALF) * HALF;
            default: ;
          endcase
        end
        m.q = t[W-1:0];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_q",     32'(q),          32'(m.q));
      chk("model_sout",  32'(sout),       32'(m.sout));
      chk("model_valid", 32'(sout_valid), 32'(m.valid));
      chk("model_busy",  32'(busy),       32'(m.busy));
      chk("model_done",  32'(done),       32'(m.done));
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic e_i, input logic [2:0] md, input logic [W-1:0] p,
                    input logic sl, input logic sr);
    en = e_i; mode = md; pin = p; sin_l = sl; sin_r = sr;
    @(negedge clk);
  endtask

  logic [W-1:0] word;

  initial begin
    reset = 1'b0; en = 1'b0; mode = 3'd0; pin = '0; sin_l = 1'b0; sin_r = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    op(1, 3'd1, 4'b1111, 0, 0);               // ignored while in reset
    chk("reset_q", 32'(q), 32'(RV));
    reset = 1'b1;

    // Asynchronous reset between edges
    op(1, 3'd1, 4'b0011, 0, 0);
    chk("pre_reset_q", 32'(q), 32'h3);
    #2 reset = 1'b0;
    #1 chk("async_q", 32'(q), 32'(RV));
    chk("async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    op(1, 3'd1, 4'b0110, 0, 0);
    op(1, 3'd1, 4'b0110, 0, 0);
    chk("reset_hold_q", 32'(q), 32'(RV));
    reset = 1'b1;
    $display("reset phase: q=%b busy=%b", q, busy);

    // Load and shifts
    op(1, 3'd1, 4'b0101, 0, 0); chk("load_q", 32'(q), 32'h5);
    op(1, 3'd2, 4'b0000, 0, 1); chk("shl_q",  32'(q), 32'hB);
    op(1, 3'd3, 4'b0000, 0, 0); chk("shr_q",  32'(q), 32'h5);
    op(1, 3'd1, 4'b1101, 0, 0);
    op(1, 3'd6, 4'b0000, 0, 0); chk("asr_q",  32'(q), 32'hE);
    $display("shift phase: q=%b", q);

    // Rotates and enable
    op(1, 3'd1, 4'b1001, 0, 0);
    op(1, 3'd4, 4'b0000, 0, 0); chk("rol_q",  32'(q), 32'h3);
    op(1, 3'd5, 4'b0000, 0, 0); chk("ror_q",  32'(q), 32'h9);
    op(0, 3'd1, 4'b1111, 0, 0); chk("en0_q",  32'(q), 32'h9);
    $display("rotate phase: q=%b", q);

    // Serialize 1101 with a load attempt held on during the whole run
    word = 4'b1101;
    op(1, 3'd7, word, 0, 0);
    chk("start_busy",  32'(busy), 32'h1);
    chk("start_valid", 32'(sout_valid), 32'h0);
    for (int i = 0; i < W; i++) begin
      op(1, 3'd1, 4'b1111, 1, 1);
      chk("ser1_bit",   32'(sout), 32'(word[W-1-i]));
      chk("ser1_valid", 32'(sout_valid), 32'h1);
      chk("ser1_busy",  32'(busy), 32'h1);
      $display("word1 bit %0d: sout=%b valid=%b", i, sout, sout_valid);
    end
    op(1, 3'd7, 4'b1111, 0, 0);               // restart attempt while busy
    chk("done1",       32'(done), 32'h1);
    chk("done1_busy",  32'(busy), 32'h0);
    chk("done1_valid", 32'(sout_valid), 32'h0);
    chk("done1_q",     32'(q), 32'h0);

    // Back-to-back restart issued in the done cycle
    word = 4'b0110;
    op(1, 3'd7, word, 0, 0);
    chk("ser2_bit0",   32'(sout), 32'(word[W-1]));
    chk("ser2_valid0", 32'(sout_valid), 32'h1);
    chk("ser2_done0",  32'(done), 32'h0);
    for (int i = 1; i < W; i++) begin
      op(0, 3'd0, 4'b0000, 0, 0);
      chk("ser2_bit",   32'(sout), 32'(word[W-1-i]));
      chk("ser2_valid", 32'(sout_valid), 32'h1);
      $display("word2 bit %0d: sout=%b valid=%b", i, sout, sout_valid);
    end
    op(0, 3'd0, 4'b0000, 0, 0); chk("done2",      32'(done), 32'h1);
    op(0, 3'd0, 4'b0000, 0, 0); chk("done2_once", 32'(done), 32'h0);

    // Abort after the second bit
    op(1, 3'd7, 4'b1011, 0, 0);
    op(0, 3'd0, 4'b0000, 0, 0);
    op(0, 3'd0, 4'b0000, 0, 0);
    chk("abort_pre_valid", 32'(sout_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy",  32'(busy), 32'h0);
    chk("abort_valid", 32'(sout_valid), 32'h0);
    chk("abort_sout",  32'(sout), 32'h0);
    chk("abort_done",  32'(done), 32'h0);
    chk("abort_q",     32'(q), 32'(RV));
    @(negedge clk);
    op(0, 3'd0, 4'b0000, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op(0, 3'd0, 4'b0000, 0, 0);
      chk("post_abort_done", 32'(done), 32'h0);
    end
    $display("abort phase: q=%b busy=%b done=%b", q, busy, done);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
